// File: rtl/proc_controller_if.sv
// rtl/proc_controller_if.sv - instruction ROM and datapath control bundle for proc_controller
interface proc_controller_if #(
    parameter int PC_W = 8,
    parameter int IR_W = 16
);
    logic [IR_W-1:0] I_data;
    logic [PC_W-1:0] I_addr;
    logic [7:0]      D_Addr;
    logic            D_rd;
    logic            D_wr;
    logic            RF_s;
    logic [3:0]      RF_W_addr;
    logic            RF_W_en;
    logic [3:0]      RF_Ra_addr;
    logic [3:0]      RF_Rb_addr;
    logic [2:0]      ALU_s0;

    modport master (
        input  I_data,
        output I_addr, D_Addr, D_rd, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0
    );

    modport slave (
        output I_data,
        input  I_addr, D_Addr, D_rd, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0
    );
endinterface

// File: rtl/proc_controller.sv
// rtl/proc_controller.sv - fetch/decode/execute Moore control unit owning PC and IR
module proc_controller #(
    parameter int PC_W = 8,
    parameter int IR_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    proc_controller_if.master bus,
    output logic [PC_W-1:0]  PC_Out,
    output logic [IR_W-1:0]  IR_Out,
    output logic [3:0]       StateO
);
    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOADA  = 4'd4,
        S_LOADB  = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    typedef struct packed {
        logic [7:0] d_addr;
        logic       d_rd;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] w_addr;
        logic       w_en;
        logic [3:0] ra_addr;
        logic [3:0] rb_addr;
        logic [2:0] alu_s;
    } ctrl_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IR_W-1:0] ir_q, ir_d;
    ctrl_t           ctrl_q, ctrl_d;
    ctrl_t           ctrl_o;
    logic [3:0]      opcode;

    assign opcode = ir_q[IR_W-1 -: 4];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = bus.I_data;
                pc_d    = pc_q + PC_W'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    4'b0010: state_d = S_LOADA;
                    4'b0001: state_d = S_STORE;
                    4'b0011: state_d = S_ADD;
                    4'b0100: state_d = S_SUB;
                    4'b0101: state_d = S_HALT;
                    default: state_d = S_NOOP;
                endcase
            end
            S_LOADA:  state_d = S_LOADB;
            S_HALT:   state_d = S_HALT;
            S_LOADB, S_STORE, S_ADD, S_SUB, S_NOOP: state_d = S_FETCH;
            default:  state_d = S_INIT;
        endcase
    end

    // Controls are decoded from the next state so the registered copy lines up with state_q.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_LOADA: begin
                ctrl_d.d_addr = ir_d[11:4];
                ctrl_d.d_rd   = 1'b1;
            end
            S_LOADB: begin
                ctrl_d.d_addr = ir_d[11:4];
                ctrl_d.d_rd   = 1'b1;
                ctrl_d.rf_s   = 1'b1;
                ctrl_d.w_addr = ir_d[3:0];
                ctrl_d.w_en   = 1'b1;
            end
            S_STORE: begin
                ctrl_d.d_addr  = ir_d[11:4];
                ctrl_d.d_wr    = 1'b1;
                ctrl_d.ra_addr = ir_d[3:0];
            end
            S_ADD, S_SUB: begin
                ctrl_d.ra_addr = ir_d[11:8];
                ctrl_d.rb_addr = ir_d[7:4];
                ctrl_d.w_addr  = ir_d[3:0];
                ctrl_d.w_en    = 1'b1;
                ctrl_d.alu_s   = (state_d == S_ADD) ? 3'd1 : 3'd2;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_INIT;
            pc_q    <= '0;
            ir_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Reset kills any in-flight write in the same cycle it is raised.
    assign ctrl_o = Reset ? '0 : ctrl_q;

    assign bus.I_addr     = pc_q;
    assign bus.D_Addr     = ctrl_o.d_addr;
    assign bus.D_rd       = ctrl_o.d_rd;
    assign bus.D_wr       = ctrl_o.d_wr;
    assign bus.RF_s       = ctrl_o.rf_s;
    assign bus.RF_W_addr  = ctrl_o.w_addr;
    assign bus.RF_W_en    = ctrl_o.w_en;
    assign bus.RF_Ra_addr = ctrl_o.ra_addr;
    assign bus.RF_Rb_addr = ctrl_o.rb_addr;
    assign bus.ALU_s0     = ctrl_o.alu_s;

    assign PC_Out = pc_q;
    assign IR_Out = ir_q;
    assign StateO = state_q;
endmodule

// File: tb/tb_proc_controller.sv
// tb/tb_proc_controller.sv - self-checking bench for proc_controller
module tb_proc_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  PC_Out;
    logic [15:0] IR_Out;
    logic [3:0]  StateO;
    logic [15:0] rom [256];

    proc_controller_if #(.PC_W(8), .IR_W(16)) bus ();

    proc_controller #(.PC_W(8), .IR_W(16)) dut (
        .Clk    (clk),
        .Reset  (reset),
        .bus    (bus),
        .PC_Out (PC_Out),
        .IR_Out (IR_Out),
        .StateO (StateO)
    );

    always #5 clk = ~clk;
    always @(posedge clk) bus.I_data <= rom[bus.I_addr];

    typedef struct packed {
        logic [3:0]  st;
        logic [7:0]  pc;
        logic [7:0]  ia;
        logic [15:0] ir;
        logic [7:0]  da;
        logic        rd;
        logic        wr;
        logic        rfs;
        logic [3:0]  wa;
        logic        we;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  alu;
    } obs_t;

    typedef struct {
        logic [15:0] ir;
        obs_t        exp;
    } vec_t;

    int   vectors = 0;
    int   miscompares = 0;
    obs_t exp_q [$];
    vec_t tbl [9];

    function automatic obs_t mk(logic [3:0] st, logic [7:0] pc, logic [15:0] ir);
        obs_t o = '0;
        o.st = st; o.pc = pc; o.ia = pc; o.ir = ir;
        return o;
    endfunction

    function automatic obs_t full(logic [3:0] st, logic [15:0] ir, logic [7:0] da,
                                  logic rd, logic wr, logic rfs, logic [3:0] wa,
                                  logic we, logic [3:0] ra, logic [3:0] rb, logic [2:0] alu);
        obs_t o = mk(st, 8'h01, ir);
        o.da = da; o.rd = rd; o.wr = wr; o.rfs = rfs; o.wa = wa;
        o.we = we; o.ra = ra; o.rb = rb; o.alu = alu;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.st = StateO; o.pc = PC_Out; o.ia = bus.I_addr; o.ir = IR_Out;
        o.da = bus.D_Addr; o.rd = bus.D_rd; o.wr = bus.D_wr; o.rfs = bus.RF_s;
        o.wa = bus.RF_W_addr; o.we = bus.RF_W_en; o.ra = bus.RF_Ra_addr;
        o.rb = bus.RF_Rb_addr; o.alu = bus.ALU_s0;
        return o;
    endfunction

    task automatic check_obs(input string name, input int idx, input obs_t got, input obs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got st=%0d pc=%h ia=%h ir=%h da=%h rd=%b wr=%b s=%b wa=%h we=%b ra=%h rb=%h alu=%0d required st=%0d pc=%h ia=%h ir=%h da=%h rd=%b wr=%b s=%b wa=%h we=%b ra=%h rb=%h alu=%0d",
                     name, idx, got.st, got.pc, got.ia, got.ir, got.da, got.rd, got.wr, got.rfs,
                     got.wa, got.we, got.ra, got.rb, got.alu, exp.st, exp.pc, exp.ia, exp.ir,
                     exp.da, exp.rd, exp.wr, exp.rfs, exp.wa, exp.we, exp.ra, exp.rb, exp.alu);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Expected per-cycle trace expanded instruction by instruction from the ROM image.
    task automatic build(input int n);
        logic [7:0]  pc = 8'h00;
        logic [15:0] ir = 16'h0000;
        obs_t        r;
        exp_q.delete();
        exp_q.push_back(mk(4'd0, pc, ir));
        while (exp_q.size() < n) begin
            exp_q.push_back(mk(4'd1, pc, ir));
            ir = rom[pc];
            pc = pc + 8'd1;
            exp_q.push_back(mk(4'd2, pc, ir));
            r = mk(4'd3, pc, ir);
            case (ir[15:12])
                4'h2: begin
                    r.st = 4'd4; r.da = ir[11:4]; r.rd = 1'b1;
                    exp_q.push_back(r);
                    r.st = 4'd5; r.rfs = 1'b1; r.wa = ir[3:0]; r.we = 1'b1;
                end
                4'h1: begin
                    r.st = 4'd6; r.da = ir[11:4]; r.wr = 1'b1; r.ra = ir[3:0];
                end
                4'h3, 4'h4: begin
                    r.st  = (ir[15:12] == 4'h3) ? 4'd7 : 4'd8;
                    r.alu = (ir[15:12] == 4'h3) ? 3'd1 : 3'd2;
                    r.ra = ir[11:8]; r.rb = ir[7:4]; r.wa = ir[3:0]; r.we = 1'b1;
                end
                4'h5: r.st = 4'd9;
                default: r.st = 4'd3;
            endcase
            if (r.st == 4'd9) begin
                while (exp_q.size() < n) exp_q.push_back(r);
            end else begin
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic run_program(input string name, input int n);
        do_reset();
        build(n);
        for (int i = 0; i < n; i++) begin
            check_obs(name, i, observe(), exp_q[i]);
            tick();
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    initial begin
        int start_i, end_i, fetches, op;

        tbl[0] = '{16'h0000, full(4'd3, 16'h0000, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0)};
        tbl[1] = '{16'h21A3, full(4'd4, 16'h21A3, 8'h1A, 1, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0)};
        tbl[2] = '{16'h1055, full(4'd6, 16'h1055, 8'h05, 0, 1, 0, 4'h0, 0, 4'h5, 4'h0, 3'd0)};
        tbl[3] = '{16'h3125, full(4'd7, 16'h3125, 8'h00, 0, 0, 0, 4'h5, 1, 4'h1, 4'h2, 3'd1)};
        tbl[4] = '{16'h4125, full(4'd8, 16'h4125, 8'h00, 0, 0, 0, 4'h5, 1, 4'h1, 4'h2, 3'd2)};
        tbl[5] = '{16'hF000, full(4'd3, 16'hF000, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0)};
        tbl[6] = '{16'h5000, full(4'd9, 16'h5000, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0)};
        tbl[7] = '{16'h6ABC, full(4'd3, 16'h6ABC, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0)};
        tbl[8] = '{16'h2FF0, full(4'd4, 16'h2FF0, 8'hFF, 1, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0)};

        clear_rom();
        tick();
        tick();
        check_obs("reset_state", 0, observe(), mk(4'd0, 8'h00, 16'h0000));

        foreach (tbl[k]) begin
            clear_rom();
            rom[0] = tbl[k].ir;
            do_reset();
            repeat (3) tick();
            check_obs("table_exec", k, observe(), tbl[k].exp);
        end

        clear_rom();
        run_program("noop_start", 8);

        clear_rom();
        rom[0] = 16'h21A3;
        run_program("load", 9);

        clear_rom();
        rom[0] = 16'h1055; rom[1] = 16'h3125; rom[2] = 16'h4125;
        run_program("store_add_sub", 14);

        do_reset();
        start_i = -1; end_i = -1; fetches = 0;
        for (int i = 0; i < 60 && fetches < 4; i++) begin
            if (StateO == 4'd1) begin
                fetches++;
                if (fetches == 1) start_i = i;
                if (fetches == 4) end_i = i;
            end
            if (fetches < 4) tick();
        end
        check_val("fetch1_to_fetch4_cycles", end_i - start_i, 9);

        clear_rom();
        rom[0] = 16'h5000;
        run_program("halt", 26);
        reset = 1'b1;
        tick();
        check_val("halt_reset_state", int'(StateO), 0);
        check_val("halt_reset_pc", int'(PC_Out), 0);

        clear_rom();
        do_reset();
        repeat (766) tick();
        check_val("wrap_last_fetch_state", int'(StateO), 1);
        check_val("wrap_last_fetch_pc", int'(PC_Out), 255);
        tick();
        check_val("wrap_pc_after_256", int'(PC_Out), 0);

        clear_rom();
        rom[0] = 16'h1055;
        do_reset();
        repeat (3) tick();
        check_val("store_wr_before_reset", int'(bus.D_wr), 1);
        reset = 1'b1;
        #1;
        check_obs("reset_in_store", 0, observe(), mk(4'd6, 8'h01, 16'h1055));
        tick();
        check_val("reset_in_store_next", int'(StateO), 0);

        clear_rom();
        rom[0] = 16'h21A3;
        do_reset();
        repeat (4) tick();
        check_val("loadb_we_before_reset", int'(bus.RF_W_en), 1);
        reset = 1'b1;
        #1;
        check_obs("reset_in_loadb", 0, observe(), mk(4'd5, 8'h01, 16'h21A3));
        tick();
        check_val("reset_in_loadb_next", int'(StateO), 0);

        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 256; i++) begin
                case ($urandom_range(0, 5))
                    0: op = 0;
                    1: op = 1;
                    2: op = 2;
                    3: op = 3;
                    4: op = 4;
                    default: op = int'($urandom_range(6, 15));
                endcase
                if ($urandom_range(0, 79) == 0) op = 5;
                rom[i] = {op[3:0], 12'($urandom)};
            end
            run_program("random", 500);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/proc_controller.md
# proc_controller

Control unit of the Lab B processor: owns the program counter and instruction register, sequences fetch/decode/execute through a Moore state machine, and drives datapath controls (data memory, register file, ALU, write-back mux). It feeds `PC_Out`, `IR_Out` and `StateO` to the board-level hex display logic. It sits between the instruction ROM upstream and the datapath downstream.

## Interface
Parameters:
- `PC_W`, 8, program counter / instruction address width
- `IR_W`, 16, instruction width

Ports:
- `Clk`  in  1  system clock, rising edge
- `Reset`  in  1  synchronous, active-high reset
- `I_data`  in  16  instruction ROM read data (registered ROM, 1-cycle read latency from `I_addr`)
- `I_addr`  out  8  instruction ROM address; equals `PC_Out`
- `PC_Out`  out  8  program counter
- `IR_Out`  out  16  instruction register
- `StateO`  out  4  current state encoding
- `D_Addr`  out  8  data memory address
- `D_rd`  out  1  data memory read enable
- `D_wr`  out  1  data memory write enable
- `RF_s`  out  1  write-back mux select: 0 = ALU result, 1 = data memory
- `RF_W_addr`  out  4  register file write address
- `RF_W_en`  out  1  register file write enable
- `RF_Ra_addr`  out  4  register file read port A address
- `RF_Rb_addr`  out  4  register file read port B address
- `ALU_s0`  out  3  ALU function: 0 = pass zero, 1 = A+B, 2 = A−B

## Operation
- Instruction fields: opcode = IR[15:12].
  - LOAD 0010: R[IR[3:0]] ← D[IR[11:4]].
  - STORE 0001: D[IR[11:4]] ← R[IR[3:0]].
  - ADD 0011: R[IR[3:0]] ← R[IR[11:8]] + R[IR[7:4]].
  - SUB 0100: R[IR[3:0]] ← R[IR[11:8]] − R[IR[7:4]].
  - HALT 0101.
  - NOOP 0000; all other opcodes execute as NOOP.
- States (`StateO` value): Init 0, Fetch 1, Decode 2, NoOp 3, LoadA 4, LoadB 5, Store 6, Add 7, Sub 8, Halt 9.
- State transitions:
  - Init → Fetch.
  - Fetch → Decode.
  - Decode → state selected by opcode.
  - LoadA → LoadB.
  - LoadB, Store, Add, Sub, NoOp → Fetch.
  - Halt → Halt until `Reset`.
- Fetch: IR ← `I_data`; PC ← PC+1, modulo 256 (0xFF wraps to 0x00).
- LoadA: `D_Addr`=IR[11:4], `D_rd`=1.
- LoadB: `D_Addr`=IR[11:4], `D_rd`=1, `RF_s`=1, `RF_W_addr`=IR[3:0], `RF_W_en`=1.
- Store: `D_Addr`=IR[11:4], `D_wr`=1, `RF_Ra_addr`=IR[3:0].
- Add/Sub:
  - `RF_Ra_addr`=IR[11:8], `RF_Rb_addr`=IR[7:4], `RF_W_addr`=IR[3:0], `RF_W_en`=1, `RF_s`=0.
  - `ALU_s0`=1 for Add, 2 for Sub.
- Default: every control output not listed for a state is 0.
- PC and IR change only in Fetch. They hold in every other state, including Halt.

## Timing
- Reset (sampled at a rising edge):
  - State=Init, PC=0x00, IR=0x0000.
  - All control outputs are 0 while `Reset` is high. This gating is combinational, so a reset asserted during Store or LoadB produces no memory or register write in that cycle.
- Controls are Moore outputs, decoded from the registered state and IR; no combinational path from `I_data`.
- ROM alignment: PC is stable for at least one cycle before each Fetch, so `I_data` in Fetch corresponds to the current PC.
- Cycle counts: Fetch+Decode = 2 cycles overhead. NOOP/STORE/ADD/SUB = 3 cycles per instruction; LOAD = 4.
- The first instruction is latched in the 2nd cycle after reset release (Init, then Fetch).
- Halt: `StateO`=9, all controls 0, PC and IR frozen. Only `Reset` exits Halt.

## Test plan
- Reset release with ROM[0]=0x0000:
  - `StateO` sequence 0,1,2,3,1.
  - PC=0x01 after first Fetch; IR=0x0000; all controls 0 throughout.
- ROM[0]=0x21A3 (LOAD R3←D[0x1A]):
  - LoadA: `D_Addr`=0x1A, `D_rd`=1.
  - LoadB: additionally `RF_s`=1, `RF_W_addr`=3, `RF_W_en`=1.
  - Next state is Fetch.
- ROM = 0x1055, 0x3125, 0x4125 (STORE, ADD, SUB):
  - Store: `D_Addr`=0x05, `D_wr`=1, `RF_Ra_addr`=5.
  - Add: Ra=1, Rb=2, W=5, `ALU_s0`=1.
  - Sub: `ALU_s0`=2.
  - Total 9 cycles from the first Fetch to the fourth Fetch.
- ROM[0]=0x5000 (HALT): `StateO` stays 9 for 20 cycles with PC=0x01 frozen; assert `Reset` → next cycle `StateO`=0, PC=0x00.
- ROM filled with NOOP: after 256 instruction fetches, PC wraps 0xFF→0x00.
- Reset asserted during a Store or LoadB cycle: `D_wr` and `RF_W_en` are 0 in that cycle; the next state is Init.
- Opcode 0xF000: executes as NOOP (`StateO`=3), with no writes.
